// File: rtl/fu_sequencer.sv
// fu_sequencer
//   Request-side controller for the ALU function unit. Accepts one request at
//   a time, drives the function unit inputs, and captures the result and flags
//   into a held result register. A multiply request runs MUL_STEPS
//   shift-and-add iterations, using the unit's ADD function for every step.
//
// Handshakes (both sides): a transfer happens on a rising CLK edge where
//   valid && ready are both high. The request side must hold REQ_* stable
//   until REQ_READY. The result side holds RES_* stable until RES_READY.
//
// Ports
//   CLK, RESET            clock, synchronous active-high reset
//   REQ_VALID/REQ_READY   request handshake
//   REQ_MUL               1 = multiply, 0 = single function-unit op
//   REQ_FS, REQ_SH        function select / shift amount for a single op
//   REQ_A, REQ_B          operands
//   FU_A/FU_B/FU_SH/FU_FS function unit inputs (0 when idle or done)
//   FU_F, FU_Z/C/N/V      function unit result and flags (combinational)
//   RES_VALID/RES_READY   result handshake
//   RES_F, RES_Z/C/N/V    captured result and flags
//   BUSY                  high whenever not IDLE
//   DBG_STATE             current FSM state (IDLE=0, EXEC=1, MUL=2, DONE=3)
module fu_sequencer #(
  parameter logic [4:0] ADD_FS    = 5'b00010,
  parameter int         MUL_STEPS = 32
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_MUL,
  input  logic [4:0]  REQ_FS,
  input  logic [31:0] REQ_A,
  input  logic [31:0] REQ_B,
  input  logic [4:0]  REQ_SH,
  output logic [31:0] FU_A,
  output logic [31:0] FU_B,
  output logic [4:0]  FU_SH,
  output logic [4:0]  FU_FS,
  input  logic [31:0] FU_F,
  input  logic        FU_Z,
  input  logic        FU_C,
  input  logic        FU_N,
  input  logic        FU_V,
  output logic        RES_VALID,
  input  logic        RES_READY,
  output logic [31:0] RES_F,
  output logic        RES_Z,
  output logic        RES_C,
  output logic        RES_N,
  output logic        RES_V,
  output logic        BUSY,
  output logic [1:0]  DBG_STATE
);

  localparam int CNT_W = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [4:0]        sh_q, sh_d;
  logic [4:0]        fs_q, fs_d;
  logic [31:0]       acc_q, acc_d;
  logic [31:0]       mcand_q, mcand_d;
  logic [31:0]       mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       res_f_q, res_f_d;
  logic              res_z_q, res_z_d;
  logic              res_c_q, res_c_d;
  logic              res_n_q, res_n_d;
  logic              res_v_q, res_v_d;

  // Function unit drive is decoded from state and internal registers only,
  // so no request or result-side input reaches it combinationally.
  always_comb begin
    FU_A  = '0;
    FU_B  = '0;
    FU_SH = '0;
    FU_FS = '0;
    case (state_q)
      S_EXEC: begin
        FU_A  = a_q;
        FU_B  = b_q;
        FU_SH = sh_q;
        FU_FS = fs_q;
      end
      S_MUL: begin
        FU_A  = acc_q;
        FU_B  = mplier_q[0] ? mcand_q : 32'd0;
        FU_FS = ADD_FS;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sh_d     = sh_q;
    fs_d     = fs_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    res_f_d  = res_f_q;
    res_z_d  = res_z_q;
    res_c_d  = res_c_q;
    res_n_d  = res_n_q;
    res_v_d  = res_v_q;
    case (state_q)
      S_IDLE: begin
        if (REQ_VALID) begin
          a_d  = REQ_A;
          b_d  = REQ_B;
          sh_d = REQ_SH;
          fs_d = REQ_FS;
          if (REQ_MUL) begin
            acc_d    = '0;
            mcand_d  = REQ_A;
            mplier_d = REQ_B;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        res_f_d = FU_F;
        res_z_d = FU_Z;
        res_c_d = FU_C;
        res_n_d = FU_N;
        res_v_d = FU_V;
        state_d = S_DONE;
      end
      S_MUL: begin
        acc_d    = FU_F;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // Low word of the product; unit carry/overflow are meaningless here.
          res_f_d = FU_F;
          res_z_d = (FU_F == 32'd0);
          res_c_d = 1'b0;
          res_n_d = FU_F[31];
          res_v_d = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (RES_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sh_q     <= '0;
      fs_q     <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      res_f_q  <= '0;
      res_z_q  <= 1'b0;
      res_c_q  <= 1'b0;
      res_n_q  <= 1'b0;
      res_v_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sh_q     <= sh_d;
      fs_q     <= fs_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      res_f_q  <= res_f_d;
      res_z_q  <= res_z_d;
      res_c_q  <= res_c_d;
      res_n_q  <= res_n_d;
      res_v_q  <= res_v_d;
    end
  end

  assign REQ_READY = (state_q == S_IDLE);
  assign BUSY      = (state_q != S_IDLE);
  assign RES_VALID = (state_q == S_DONE);
  assign RES_F     = res_f_q;
  assign RES_Z     = res_z_q;
  assign RES_C     = res_c_q;
  assign RES_N     = res_n_q;
  assign RES_V     = res_v_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_fu_sequencer.sv
// Testbench for fu_sequencer: behavioural function unit, directed and random
// requests, scoreboard queue of expected {F,Z,C,N,V}, monitor on the result
// handshake, and a final report line.
module tb_fu_sequencer;

  localparam logic [4:0] ADD_FS = 5'b00010;
  localparam int MUL_STEPS = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_mul;
  logic [4:0]  req_fs;
  logic [31:0] req_a, req_b;
  logic [4:0]  req_sh;
  logic [31:0] fu_a, fu_b;
  logic [4:0]  fu_sh, fu_fs;
  logic [31:0] fu_f;
  logic        fu_z, fu_c, fu_n, fu_v;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_f;
  logic        res_z, res_c, res_n, res_v;
  logic        busy;
  logic [1:0]  dbg_state;

  logic        rr_fixed = 1'b1;
  logic        rr_rand = 1'b1;
  logic        rand_rr = 1'b0;
  assign res_ready = rand_rr ? rr_rand : rr_fixed;

  int checks = 0;
  int failures = 0;
  logic [35:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  fu_sequencer #(.ADD_FS(ADD_FS), .MUL_STEPS(MUL_STEPS)) dut (
    .CLK(clk), .RESET(reset),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_MUL(req_mul),
    .REQ_FS(req_fs), .REQ_A(req_a), .REQ_B(req_b), .REQ_SH(req_sh),
    .FU_A(fu_a), .FU_B(fu_b), .FU_SH(fu_sh), .FU_FS(fu_fs),
    .FU_F(fu_f), .FU_Z(fu_z), .FU_C(fu_c), .FU_N(fu_n), .FU_V(fu_v),
    .RES_VALID(res_valid), .RES_READY(res_ready), .RES_F(res_f),
    .RES_Z(res_z), .RES_C(res_c), .RES_N(res_n), .RES_V(res_v),
    .BUSY(busy), .DBG_STATE(dbg_state)
  );

  // ---------------- function unit model ----------------
  // Returns {F, Z, C, N, V}.
  function automatic logic [35:0] fu_model(input logic [4:0] fs, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh);
    logic [32:0] s;
    logic [31:0] f;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    s = '0;
    case (fs)
      5'd2: begin
        s = {1'b0, a} + {1'b0, b};
        f = s[31:0];
        c = s[32];
        v = (a[31] == b[31]) && (f[31] != a[31]);
      end
      5'd5: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        f = s[31:0];
        c = s[32];
        v = (a[31] != b[31]) && (f[31] != a[31]);
      end
      5'd8:    f = a & b;
      5'd9:    f = a | b;
      5'd10:   f = a ^ b;
      5'd12:   f = a << sh;
      5'd13:   f = a >> sh;
      default: f = a;
    endcase
    return {f, (f == 32'd0), c, f[31], v};
  endfunction

  always_comb {fu_f, fu_z, fu_c, fu_n, fu_v} = fu_model(fu_fs, fu_a, fu_b, fu_sh);

  // Expected result of a whole request.
  function automatic logic [35:0] ref_result(input bit mul, input logic [4:0] fs,
                                             input logic [31:0] a, input logic [31:0] b,
                                             input logic [4:0] sh);
    logic [31:0] p;
    if (mul) begin
      p = a * b;
      return {p, (p == 32'd0), 1'b0, p[31], 1'b0};
    end
    return fu_model(fs, a, b, sh);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input bit mul, input logic [4:0] fs, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh);
    int w;
    @(negedge clk);
    req_mul = mul; req_fs = fs; req_a = a; req_b = b; req_sh = sh;
    req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) check("req_ready_timeout", 1, 0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Waits for RES_VALID after acceptance; optionally pokes a stray request mid-flight.
  task automatic wait_result(input int exp_lat, input bit ghost);
    int lat;
    lat = 0;
    while (!res_valid && lat < 100) begin
      @(negedge clk);
      lat++;
      if (ghost && lat == 5) begin
        req_valid = 1'b1;
        req_mul = 1'($urandom_range(0, 1));
        req_fs = ADD_FS;
        req_a = $urandom;
        req_b = $urandom;
      end
      if (ghost && lat == 7) req_valid = 1'b0;
    end
    check("result_latency", 64'(lat), 64'(exp_lat));
  endtask

  task automatic send(input bit mul, input logic [4:0] fs, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] sh, input bit ghost);
    exp_q.push_back(ref_result(mul, fs, a, b, sh));
    issue(mul, fs, a, b, sh);
    wait_result(mul ? MUL_STEPS : 1, ghost);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic        have_prev = 1'b0;
  logic [35:0] prev_res;

  always @(negedge clk) rr_rand <= 1'($urandom_range(0, 1));

  always begin
    logic [35:0] exp;
    @(negedge clk);
    #1;
    if (reset) begin
      have_prev = 1'b0;
    end else begin
      if (have_prev && res_valid)
        check("res_hold_stable", {28'd0, res_f, res_z, res_c, res_n, res_v}, {28'd0, prev_res});
      have_prev = res_valid && !res_ready;
      prev_res = {res_f, res_z, res_c, res_n, res_v};
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          exp = exp_q.pop_front();
          check("result_fznc v", {28'd0, res_f, res_z, res_c, res_n, res_v}, {28'd0, exp});
        end
      end
    end
  end

  // ---------------- main stimulus ----------------
  initial begin
    logic [4:0] fs_tab [8];
    fs_tab = '{5'd0, 5'd2, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12, 5'd13};
    reset = 1'b1; req_valid = 1'b0; req_mul = 1'b0; req_fs = '0;
    req_a = '0; req_b = '0; req_sh = '0;
    repeat (3) @(negedge clk);
    check("reset_req_ready", 64'(req_ready), 1);
    check("reset_busy", 64'(busy), 0);
    check("reset_res_valid", 64'(res_valid), 0);
    check("reset_res", {28'd0, res_f, res_z, res_c, res_n, res_v}, 0);
    check("reset_fu", {fu_a, fu_b[26:0], fu_sh} | 64'(fu_fs) | 64'(fu_b), 0);
    reset = 1'b0;

    // Directed cases.
    send(1'b0, ADD_FS, 32'd5, 32'd7, 5'd0, 1'b0);
    send(1'b0, ADD_FS, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
    send(1'b1, 5'd0, 32'd3, 32'hFFFF_FFFE, 5'd0, 1'b0);
    send(1'b1, 5'd0, 32'h0001_0000, 32'h0001_0000, 5'd0, 1'b0);
    send(1'b0, 5'd5, 32'h8000_0000, 32'd1, 5'd0, 1'b0);
    send(1'b0, 5'd12, 32'h0000_00F1, 32'd0, 5'd4, 1'b0);

    // Idle-state FU drive.
    @(negedge clk);
    check("idle_fu_a", 64'(fu_a), 0);
    check("idle_fu_fs", 64'(fu_fs), 0);

    // Backpressure.
    rr_fixed = 1'b0;
    send(1'b0, 5'd10, 32'hDEAD_BEEF, 32'h1234_5678, 5'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_req_ready_low", {62'd0, req_ready, res_valid}, 64'b01);
    end
    rr_fixed = 1'b1;
    @(negedge clk);
    check("bp_after_handshake", {62'd0, req_ready, res_valid}, 64'b10);

    // Reset in the middle of a multiply.
    issue(1'b1, 5'd0, 32'h1234_5678, 32'h9ABC_DEF1, 5'd0);
    repeat (9) @(negedge clk);
    check("mid_mul_busy", 64'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_idle", {61'd0, req_ready, busy, res_valid}, 64'b100);
    check("abort_fu", 64'(fu_a) | 64'(fu_b) | 64'(fu_sh) | 64'(fu_fs), 0);
    reset = 1'b0;
    send(1'b0, ADD_FS, 32'd1, 32'd1, 5'd0, 1'b0);

    // Stray request during a multiply is ignored.
    send(1'b1, 5'd0, 32'hFFFF_FFF9, 32'd6, 5'd0, 1'b1);

    // Random mix with random result backpressure.
    rand_rr = 1'b1;
    for (int n = 0; n < 24; n++) begin
      send(($urandom_range(0, 3) == 0), fs_tab[$urandom_range(0, 7)],
           $urandom, $urandom, 5'($urandom_range(0, 31)), 1'b0);
    end
    rand_rr = 1'b0;
    repeat (5) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 0);
    check("final_idle", 64'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/fu_sequencer.md
# fu_sequencer

Request-side controller for the ALU function unit. It accepts operation requests over a valid/ready handshake and drives the function unit's A/B/SH/FS inputs. It captures F and the Z/C/N/V flags into a held result register. It also runs a 32-step shift-and-add multiply by iterating the unit's ADD function. It sits between instruction decode and register writeback, and it is the only driver of the function unit inputs.

## Interface
Parameters:
- ADD_FS, 5'b00010, FS code the function unit decodes as A+B; used for every multiply step.
- MUL_STEPS, 32, number of multiply iterations (equals operand width).

Ports:
- CLK  in  1  rising-edge clock.
- RESET  in  1  synchronous, active-high reset. Sampled on rising edge of CLK.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  sequencer can accept a request.
- REQ_MUL  in  1  1 = multiply request; 0 = single function-unit op.
- REQ_FS  in  5  FS code for a single op. Ignored when REQ_MUL=1.
- REQ_A, REQ_B  in  32  operands.
- REQ_SH  in  5  shift amount for a single op.
- FU_A, FU_B  out  32  to function unit A, B.
- FU_SH  out  5  to function unit SH.
- FU_FS  out  5  to function unit FS.
- FU_F  in  32  function unit result. Combinational in the same cycle.
- FU_Z, FU_C, FU_N, FU_V  in  1  function unit flags.
- RES_VALID  out  1  result register holds an unconsumed result.
- RES_READY  in  1  consumer takes the result.
- RES_F  out  32  captured result.
- RES_Z, RES_C, RES_N, RES_V  out  1  captured flags.
- BUSY  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, EXEC, MUL, DONE. Encoding is free.
- IDLE:
  - REQ_READY=1.
  - REQ_VALID=1 latches REQ_A, REQ_B, REQ_SH, REQ_FS and REQ_MUL into internal registers.
  - Goes to EXEC if REQ_MUL=0, or to MUL if REQ_MUL=1.
  - On entry to MUL: acc=0, mcand=REQ_A, mplier=REQ_B, step counter=0.
- EXEC (one cycle):
  - Drives FU_A/FU_B/FU_SH/FU_FS from the latched operands.
  - Captures FU_F and all four flags into the RES_* registers.
  - Goes to DONE.
- MUL (MUL_STEPS cycles):
  - Drives FU_FS=ADD_FS, FU_SH=0, FU_A=acc.
  - Drives FU_B=mcand when mplier[0]=1, otherwise FU_B=0.
  - Each cycle updates acc<=FU_F, mcand<=mcand<<1, mplier<=mplier>>1, counter+1.
  - In the step where the counter reaches MUL_STEPS-1, the next state is DONE. Flag capture:
    - RES_F=FU_F for that step, i.e. the low 32 bits of the product; high bits are discarded.
    - RES_Z=(RES_F==0), RES_N=RES_F[31].
    - RES_C=0 and RES_V=0.
  - Function-unit carry/overflow are ignored during multiply. Signed operands give the correct two's-complement low word.
- DONE:
  - RES_VALID=1. RES_* are held stable until RES_VALID&&RES_READY.
  - On handshake, goes to IDLE.
  - No new request is accepted in the handshake cycle; REQ_READY rises the following cycle.
- In IDLE and DONE, FU_A/FU_B/FU_SH/FU_FS are all 0.
- REQ_VALID outside IDLE is ignored. The requester must hold the request until REQ_READY.

## Timing
- Reset values:
  - State IDLE.
  - REQ_READY=1, BUSY=0, RES_VALID=0.
  - RES_F=0, all RES flags=0.
  - FU_* = 0.
  - Internal acc, mcand, mplier and counter = 0.
- RESET has priority over all other inputs. A reset mid-EXEC or mid-MUL aborts the operation and discards partial state. Outputs take their reset values on the next edge.
- Latency, with request accepted at edge 0:
  - Single op: RES_VALID high after edge 1.
  - Multiply: RES_VALID high after edge MUL_STEPS (edge 32).
- Throughput: at minimum one request per 3 cycles (single op) or per MUL_STEPS+2 cycles (multiply), with RES_READY tied high.
- All outputs are registered or decoded only from state and internal registers. No combinational path runs from REQ_* or RES_READY to any output.

## Test plan
- Single ADD: REQ_FS=ADD_FS, A=5, B=7, RES_READY=1 -> RES_VALID one cycle after acceptance, RES_F=12, Z=C=N=V=0.
- Single op flags: FS=ADD_FS, A=0xFFFFFFFF, B=1 -> RES_F=0, Z=1, C=1.
- Multiply:
  - A=3, B=0xFFFFFFFE -> RES_VALID 32 cycles after acceptance, RES_F=0xFFFFFFFA, N=1, Z=0, C=V=0.
  - A=0x00010000, B=0x00010000 -> RES_F=0, Z=1.
- Backpressure: hold RES_READY=0 for 10 cycles after RES_VALID -> RES_* stable and REQ_READY=0 throughout. After the handshake, REQ_READY=1 one cycle later.
- Reset mid-multiply: assert RESET at MUL step 10 -> next cycle state IDLE, RES_VALID=0, FU_*=0. A following single ADD 1+1 returns RES_F=2.
- Busy ignore: pulse REQ_VALID with different operands during MUL -> ignored; the multiply result is unchanged and no extra RES_VALID occurs.
